high_radix_division: RTL

//  Sequential radix-4 restoring integer divider: 2 quotient bits/cycle, WIDTH/2 iterations.

---
 rtl/high_radix_division.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/high_radix_division.sv
// high_radix_division: sequential radix-4 restoring divider, two quotient bits per cycle.
// Define HRD_SIGNED_EN for two's-complement operands; the default build divides unsigned.

module high_radix_division #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             dbz,
    output logic             ovf
);
    localparam int HALF  = WIDTH / 2;
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int RW    = WIDTH + 2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HALF - 1);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIXUP} state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] xin_q, xin_d;
    logic [WIDTH-1:0] yin_q, yin_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbz_c_q, dbz_c_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [RW-1:0]    r_sh, d1, d2, d3;
    logic [1:0]       digit;
    logic [WIDTH-1:0] r_nxt;

`ifdef HRD_SIGNED_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;
    logic ovf_c_q, ovf_c_d;

    // Magnitude of the most-negative value is 2^(WIDTH-1), which still fits unsigned.
    function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
        return (v < 0) ? WIDTH'(-v) : WIDTH'(v);
    endfunction

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + WIDTH'(1)) : v;
    endfunction
`endif

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_PREP;
            S_PREP:  state_d = S_ITER;
            S_ITER:  if (cnt_q == LAST_CNT) state_d = S_FIXUP;
            S_FIXUP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q != S_IDLE);
        done = done_q;
        quot = quot_q;
        rem  = rem_q;
        dbz  = dbz_q;
        ovf  = ovf_q;
    end

    // Radix-4 digit selection; 3D is kept at WIDTH+2 bits so nothing is truncated.
    always_comb begin
        r_sh = {r_q, a_q[WIDTH-1:WIDTH-2]};
        d1   = {2'b00, d_q};
        d2   = {1'b0, d_q, 1'b0};
        d3   = d1 + d2;
        if (r_sh >= d3) begin
            digit = 2'd3;
            r_nxt = WIDTH'(r_sh - d3);
        end else if (r_sh >= d2) begin
            digit = 2'd2;
            r_nxt = WIDTH'(r_sh - d2);
        end else if (r_sh >= d1) begin
            digit = 2'd1;
            r_nxt = WIDTH'(r_sh - d1);
        end else begin
            digit = 2'd0;
            r_nxt = WIDTH'(r_sh);
        end
    end

    always_comb begin
        xin_d   = xin_q;
        yin_d   = yin_q;
        a_d     = a_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        dbz_c_d = dbz_c_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
`ifdef HRD_SIGNED_EN
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        ovf_c_d = ovf_c_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    xin_d = x;
                    yin_d = y;
                end
            end
            S_PREP: begin
                r_d     = '0;
                cnt_d   = '0;
                dbz_c_d = (yin_q == '0);
`ifdef HRD_SIGNED_EN
                a_d     = abs_val(xin_q);
                d_d     = abs_val(yin_q);
                qneg_d  = xin_q[WIDTH-1] ^ yin_q[WIDTH-1];
                rneg_d  = xin_q[WIDTH-1];
                ovf_c_d = (xin_q == MOST_NEG) && (yin_q == '1);
`else
                a_d     = xin_q;
                d_d     = yin_q;
`endif
            end
            S_ITER: begin
                a_d   = {a_q[WIDTH-3:0], digit};
                r_d   = r_nxt;
                cnt_d = cnt_q + CNT_W'(1);
            end
            S_FIXUP: begin
                done_d = 1'b1;
                dbz_d  = 1'b0;
                ovf_d  = 1'b0;
                if (dbz_c_q) begin
                    quot_d = '1;
                    rem_d  = xin_q;
                    dbz_d  = 1'b1;
`ifdef HRD_SIGNED_EN
                end else if (ovf_c_q) begin
                    quot_d = xin_q;
                    rem_d  = '0;
                    ovf_d  = 1'b1;
                end else begin
                    quot_d = neg_if(a_q, qneg_q);
                    rem_d  = neg_if(r_q, rneg_q);
                end
`else
                end else begin
                    quot_d = a_q;
                    rem_d  = r_q;
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xin_q   <= '0;
            yin_q   <= '0;
            a_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            dbz_c_q <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef HRD_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            ovf_c_q <= 1'b0;
`endif
        end else begin
            xin_q   <= xin_d;
            yin_q   <= yin_d;
            a_q     <= a_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            dbz_c_q <= dbz_c_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
`ifdef HRD_SIGNED_EN
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            ovf_c_q <= ovf_c_d;
`endif
        end
    end

endmodule
